div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//   Sequencer for the divider in the EX stage. Runs non-restoring division over
//   DATA_WIDTH cycles on one shared controlled add/sub (CAS) row, one quotient
//   bit per cycle. Handles signed/unsigned operands, divide-by-zero and flush.
//   Sits between the EX issue logic (start/valid handshake) and the CAS row.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; the CAS row is DATA_WIDTH+1 bits wide
// PORTS
//   clk          in   1     clock
//   rst          in   1     synchronous, active-high reset
//   div_start    in   1     request; accepted only in IDLE
//   div_signed   in   1     1 = two's-complement operands, 0 = unsigned
//   dividend     in   W     sampled on the accepted start
//   divisor      in   W     sampled on the accepted start
//   flush        in   1     abort any operation in flight
//   busy         out  1     high from the cycle after accept until valid
//   div_valid    out  1     one-cycle result strobe
//   quotient     out  W     final quotient; held until the next accept
//   remainder    out  W     final remainder; held until the next accept
//   div_by_zero  out  1     qualifies div_valid
//   row_op1      out  W+1   partial remainder to CAS row
//   row_op2      out  W+1   {1'b0, |divisor|} to CAS row
//   row_sub      out  1     1 = row subtracts, 0 = row adds
//   row_result   in   W+1   CAS row sum, combinational in the same cycle
// BEHAVIOUR
//   - Reset: state=IDLE; busy, div_valid, div_by_zero = 0; quotient, remainder
//     = 0; row_op1/op2 = 0; row_sub = 0.
//   - States: IDLE -> PREP -> CALC (W cycles) -> CORR -> FIN -> DONE -> IDLE.
//     Divide-by-zero goes IDLE -> DONE.
//   - Start accepted at edge 0: PREP runs in cycle 1, CALC in cycles 2..W+1,
//     CORR in W+2 and FIN in W+3. div_valid is high in cycle W+4 (36 for W=32).
//   - PREP: latch D=|divisor| and Q=|dividend|. Unsigned mode takes the raw
//     values. Clear R (W+1 bits). Record sq=sign(dividend)^sign(divisor) and
//     sr=sign(dividend).
//   - CALC step: row_op1={R[W-1:0],Q[W-1]} and row_sub=~R[W]. Then
//     R<=row_result and Q<={Q[W-2:0],~row_result[W]}. A 5-bit step counter
//     ends CALC after exactly W steps.
//   - CORR: row_op1=R, row_sub=0. If R[W]=1, R<=row_result; otherwise R is kept.
//   - FIN: quotient = sq ? -Q : Q and remainder = sr ? -R[W-1:0] : R[W-1:0]
//     (signed mode only).
//   - Signed overflow 0x8000_0000 / -1 needs no special path. The unsigned
//     magnitude path must give q=0x8000_0000, r=0.
//   - Divide-by-zero (divisor==0 at accept): next cycle div_valid=1,
//     div_by_zero=1, quotient=all ones, remainder=dividend. The row is unused.
//   - div_valid and div_by_zero are high for exactly one cycle (DONE). busy is
//     low in DONE. A start in DONE is ignored; it is accepted in IDLE the
//     following cycle.
//   - div_start while busy: ignored; operands are not resampled.
//   - flush, any non-IDLE state: next state is IDLE; busy=0 next cycle; no
//     div_valid; quotient/remainder keep previous results. flush beats
//     div_start in the same cycle.
//   - rst mid-operation: full reset values next cycle. rst beats flush and
//     div_start.
//   - Outside CALC/CORR, row_op1=0 and row_sub=0 (row is idle, low toggle).
// TESTING
//   1 unsigned 100/7 -> valid at cycle 36: q=14, r=2, div_by_zero=0; busy high
//     for cycles 1..35.
//   2 signed -7/2 -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1); signed 7/-2 ->
//     q=-3, r=1.
//   3 unsigned 5/0 -> valid at cycle 1: div_by_zero=1, q=0xFFFF_FFFF, r=5;
//     signed -5/0 -> r=0xFFFF_FFFB.
//   4 signed 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0; unsigned
//     0xFFFF_FFFF/1 -> q=0xFFFF_FFFF, r=0.
//   5 flush at cycle 10 -> busy=0 at cycle 11, no valid ever; outputs keep the
//     prior result; a new 9/3 start then gives q=3, r=0.
//   6 div_start pulsed at cycle 5 with other operands -> ignored, first result
//     unchanged; rst at cycle 20 -> all outputs 0 at cycle 21.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: non-restoring divider sequencer driving one shared CAS row, with sign handling, divide-by-zero and flush
module div_seq_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_div_start,
  input  logic                  i_div_signed,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_div_valid,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero,
  output logic [DATA_WIDTH:0]   o_row_op1,
  output logic [DATA_WIDTH:0]   o_row_op2,
  output logic                  o_row_sub,
  input  logic [DATA_WIDTH:0]   i_row_result
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [2:0] {IDLE, PREP, CALC, CORR, FIN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_q, r_d, r_quot, r_rem;
  logic [W:0] r_r;
  logic r_signed, r_sq, r_sr, r_dbz;
  logic w_accept, w_zero;
  assign w_zero = i_divisor == '0;
  assign w_accept = r_state == IDLE && i_div_start && !i_flush;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_div_start) w_next = w_zero ? DONE : PREP;
      PREP: w_next = CALC;
      CALC: if (r_cnt == LAST) w_next = CORR;
      CORR: w_next = FIN;
      FIN:  w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_q <= '0;
      r_d <= '0;
      r_r <= '0;
      r_quot <= '0;
      r_rem <= '0;
      r_signed <= 1'b0;
      r_sq <= 1'b0;
      r_sr <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_q <= i_dividend;
          r_d <= i_divisor;
          r_signed <= i_div_signed;
          r_dbz <= w_zero;
          if (w_zero) begin
            r_quot <= '1;
            r_rem <= i_dividend;
          end
        end
        PREP: begin
          r_q <= (r_signed && r_q[W-1]) ? -r_q : r_q;
          r_d <= (r_signed && r_d[W-1]) ? -r_d : r_d;
          r_r <= '0;
          r_cnt <= '0;
          r_sq <= r_signed && (r_q[W-1] ^ r_d[W-1]);
          r_sr <= r_signed && r_q[W-1];
        end
        CALC: begin
          r_r <= i_row_result;
          r_q <= {r_q[W-2:0], ~i_row_result[W]};
          r_cnt <= r_cnt + 1'b1;
        end
        CORR: if (r_r[W]) r_r <= i_row_result;
        FIN: if (!i_flush) begin
          r_quot <= r_sq ? -r_q : r_q;
          r_rem <= r_sr ? -r_r[W-1:0] : r_r[W-1:0];
        end
        default: ;
      endcase
    end
  end
  assign o_busy = r_state inside {PREP, CALC, CORR, FIN};
  assign o_div_valid = r_state == DONE;
  assign o_div_by_zero = r_state == DONE && r_dbz;
  assign o_quotient = r_quot;
  assign o_remainder = r_rem;
  assign o_row_op1 = r_state == CALC ? {r_r[W-1:0], r_q[W-1]} : r_state == CORR ? r_r : '0;
  assign o_row_op2 = {1'b0, r_d};
  assign o_row_sub = r_state == CALC && !r_r[W];
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vector table plus hand sequences for flush, reset, ignored starts and DONE-cycle starts
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic rst, i_div_start, i_div_signed, i_flush;
  logic [31:0] i_dividend, i_divisor, o_quotient, o_remainder;
  logic o_busy, o_div_valid, o_div_by_zero, o_row_sub;
  logic [32:0] o_row_op1, o_row_op2, w_row_result;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign w_row_result = o_row_sub ? o_row_op1 - o_row_op2 : o_row_op1 + o_row_op2;
  div_seq_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_div_start(i_div_start), .i_div_signed(i_div_signed),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_flush(i_flush),
    .o_busy(o_busy), .o_div_valid(o_div_valid), .o_quotient(o_quotient),
    .o_remainder(o_remainder), .o_div_by_zero(o_div_by_zero),
    .o_row_op1(o_row_op1), .o_row_op2(o_row_op2), .o_row_sub(o_row_sub),
    .i_row_result(w_row_result)
  );
  typedef struct {
    logic sgn;
    logic [31:0] a, b, q, r;
    logic dbz;
    int lat;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int lat, output int busy_n);
    @(negedge clk);
    i_div_start = 1'b1;
    i_div_signed = sgn;
    i_dividend = a;
    i_divisor = b;
    @(negedge clk);
    i_div_start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!o_div_valid && lat < 100) begin
      if (o_busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, busy_n, nvalid;
    vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 36};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 36};
    vecs[3] = '{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 36};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 36};
    vecs[7] = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 36};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 36};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 36};
    rst = 1'b1;
    i_div_start = 1'b0;
    i_div_signed = 1'b0;
    i_flush = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset valid", 64'(o_div_valid), 64'd0);
    chk("reset dbz", 64'(o_div_by_zero), 64'd0);
    chk("reset q", 64'(o_quotient), 64'd0);
    chk("reset r", 64'(o_remainder), 64'd0);
    chk("reset row", {29'd0, o_row_sub, o_row_op1[16:0], o_row_op2[16:0]}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_n);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 64'(busy_n), 64'(vecs[i].lat - 1));
      chk($sformatf("v%0d q", i), 64'(o_quotient), 64'(vecs[i].q));
      chk($sformatf("v%0d r", i), 64'(o_remainder), 64'(vecs[i].r));
      chk($sformatf("v%0d dbz", i), 64'(o_div_by_zero), 64'(vecs[i].dbz));
      chk($sformatf("v%0d row idle in done", i), {30'd0, o_row_sub, o_row_op1}, 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d valid one cycle", i), {62'd0, o_div_valid, o_div_by_zero}, 64'd0);
    end
    // Flush mid-operation: prior result 100/7 must survive, no strobe afterwards
    run(1'b0, 32'd100, 32'd7, lat, busy_n);
    @(negedge clk);
    i_div_start = 1'b1;
    i_dividend = 32'd1000;
    i_divisor = 32'd3;
    @(negedge clk);
    i_div_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush busy before", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush busy after", 64'(o_busy), 64'd0);
    nvalid = 0;
    for (int c = 0; c < 50; c++) begin
      if (o_div_valid) nvalid++;
      @(negedge clk);
    end
    chk("flush no valid", 64'(nvalid), 64'd0);
    chk("flush q kept", 64'(o_quotient), 64'd14);
    chk("flush r kept", 64'(o_remainder), 64'd2);
    run(1'b0, 32'd9, 32'd3, lat, busy_n);
    chk("post flush q", 64'(o_quotient), 64'd3);
    chk("post flush r", 64'(o_remainder), 64'd0);
    chk("post flush latency", 64'(lat), 64'd36);
    // Start pulsed while busy must not resample operands
    @(negedge clk);
    i_div_start = 1'b1;
    i_div_signed = 1'b0;
    i_dividend = 32'd100;
    i_divisor = 32'd7;
    @(negedge clk);
    i_div_start = 1'b0;
    repeat (4) @(negedge clk);
    i_div_start = 1'b1;
    i_dividend = 32'd50;
    i_divisor = 32'd5;
    @(negedge clk);
    i_div_start = 1'b0;
    lat = 6;
    while (!o_div_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy start latency", 64'(lat), 64'd36);
    chk("busy start q", 64'(o_quotient), 64'd14);
    chk("busy start r", 64'(o_remainder), 64'd2);
    // Reset mid-operation
    @(negedge clk);
    i_div_start = 1'b1;
    i_dividend = 32'd1000;
    i_divisor = 32'd3;
    @(negedge clk);
    i_div_start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", 64'(o_busy), 64'd0);
    chk("mid rst valid", 64'(o_div_valid), 64'd0);
    chk("mid rst q", 64'(o_quotient), 64'd0);
    chk("mid rst r", 64'(o_remainder), 64'd0);
    chk("mid rst row", {30'd0, o_row_sub, o_row_op1}, 64'd0);
    chk("mid rst op2", 64'(o_row_op2), 64'd0);
    // Start held through DONE is only accepted once back in IDLE
    @(negedge clk);
    i_div_start = 1'b1;
    i_div_signed = 1'b0;
    i_dividend = 32'd5;
    i_divisor = 32'd0;
    @(negedge clk);
    chk("done start first valid", 64'(o_div_valid), 64'd1);
    i_dividend = 32'd7;
    @(negedge clk);
    chk("done start ignored valid", 64'(o_div_valid), 64'd0);
    chk("done start ignored r", 64'(o_remainder), 64'd5);
    @(negedge clk);
    i_div_start = 1'b0;
    chk("idle start valid", 64'(o_div_valid), 64'd1);
    chk("idle start r", 64'(o_remainder), 64'd7);
    @(negedge clk);
    chk("idle start strobe end", 64'(o_div_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
